// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader_pkg
// Description : Shared loader state type and instruction-memory geometry.
// Revision    : 1.0 - initial release
// ============================================================================
package imem_loader_pkg;

    localparam int IMEM_ADDR_W = 6;
    localparam int IMEM_DEPTH  = 64;

    typedef enum logic [1:0] {
        ST_HDR  = 2'd0,
        ST_DATA = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } loader_state_t;

endpackage
`default_nettype wire

// File: rtl/imem_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader_if
// Description : Byte stream in, instruction-memory write port and status out.
// Revision    : 1.0 - initial release
// ============================================================================
interface imem_loader_if #(
    parameter int ADDR_W = imem_loader_pkg::IMEM_ADDR_W
);
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              restart;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [31:0]       wdata;
    logic              load_done;
    logic              load_err;

    modport slave (
        input  byte_valid, byte_data, restart,
        output byte_ready, we, waddr, wdata, load_done, load_err
    );

    modport master (
        output byte_valid, byte_data, restart,
        input  byte_ready, we, waddr, wdata, load_done, load_err
    );
endinterface
`default_nettype wire

// File: rtl/imem_loader_byte_to_word.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader_byte_to_word
// Description : Little-endian 4-byte assembler with registered word pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader_byte_to_word (
    input  wire logic        clk,
    input  wire logic        rstn,
    input  wire logic        i_clear,
    input  wire logic        i_valid,
    input  wire logic [7:0]  i_data,
    input  wire logic        i_emit,
    output logic             o_last,
    output logic [31:0]      o_asm_word,
    output logic             o_word_valid,
    output logic [31:0]      o_word
);
    logic [1:0]  r_cnt;
    logic [31:0] r_shift;

    // Completed word is visible combinationally so the header can be decoded on its 4th byte.
    assign o_last     = i_valid && (r_cnt == 2'd3);
    assign o_asm_word = {i_data, r_shift[31:8]};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt        <= 2'd0;
            r_shift      <= 32'd0;
            o_word_valid <= 1'b0;
            o_word       <= 32'd0;
        end else begin
            o_word_valid <= o_last && i_emit;
            if (o_last && i_emit) begin
                o_word <= o_asm_word;
            end
            if (i_clear) begin
                r_cnt   <= 2'd0;
                r_shift <= 32'd0;
            end else if (i_valid) begin
                r_cnt   <= r_cnt + 2'd1;
                r_shift <= o_asm_word;
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Loads a length-prefixed byte stream into instruction memory.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W,
    parameter int DEPTH  = IMEM_DEPTH
) (
    input  wire logic    clk,
    input  wire logic    rstn,
    imem_loader_if.slave bus
);
    loader_state_t r_state, w_state_next;

    logic [31:0]     r_n;
    logic [ADDR_W:0] r_widx;
    logic [ADDR_W:0] w_widx_inc;
    logic            r_byte_ready;
    logic            r_load_done;
    logic            r_load_err;

    logic            w_accept;
    logic            w_emit;
    logic            w_clear;
    logic            w_last;
    logic [31:0]     w_asm_word;
    logic            w_word_valid;
    logic [31:0]     w_word;

    assign w_accept   = bus.byte_valid && r_byte_ready;
    assign w_emit     = (r_state == ST_DATA);
    assign w_clear    = bus.restart && ((r_state == ST_DONE) || (r_state == ST_ERR));
    assign w_widx_inc = r_widx + (ADDR_W+1)'(1);

    imem_loader_byte_to_word u_b2w (
        .clk          (clk),
        .rstn         (rstn),
        .i_clear      (w_clear),
        .i_valid      (w_accept),
        .i_data       (bus.byte_data),
        .i_emit       (w_emit),
        .o_last       (w_last),
        .o_asm_word   (w_asm_word),
        .o_word_valid (w_word_valid),
        .o_word       (w_word)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_HDR;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_HDR: begin
                if (w_last) begin
                    if (w_asm_word == 32'd0) begin
                        w_state_next = ST_DONE;
                    end else if (w_asm_word > 32'(DEPTH)) begin
                        w_state_next = ST_ERR;
                    end else begin
                        w_state_next = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                // Leave only once the final write pulse is on the port.
                if (w_word_valid && (32'(w_widx_inc) == r_n)) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE, ST_ERR: begin
                if (bus.restart) begin
                    w_state_next = ST_HDR;
                end
            end
            default: w_state_next = ST_HDR;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_n          <= 32'd0;
            r_widx       <= '0;
            r_byte_ready <= 1'b1;
            r_load_done  <= 1'b0;
            r_load_err   <= 1'b0;
        end else begin
            r_byte_ready <= (w_state_next == ST_HDR) || (w_state_next == ST_DATA);
            r_load_done  <= (w_state_next == ST_DONE);
            r_load_err   <= (w_state_next == ST_ERR);
            if ((r_state == ST_HDR) && w_last) begin
                r_n    <= w_asm_word;
                r_widx <= '0;
            end else if ((r_state == ST_DATA) && w_word_valid) begin
                r_widx <= w_widx_inc;
            end else if (w_clear) begin
                r_n    <= 32'd0;
                r_widx <= '0;
            end
        end
    end

    assign bus.byte_ready = r_byte_ready;
    assign bus.we         = w_word_valid;
    assign bus.waddr      = r_widx[ADDR_W-1:0];
    assign bus.wdata      = w_word;
    assign bus.load_done  = r_load_done;
    assign bus.load_err   = r_load_err;
endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_loader
// Description : Directed self-checking bench with write-port scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader;
    logic clk;
    logic rstn;
    int   total;
    int   bad;
    int   cyc;

    typedef struct {
        logic [5:0]  a;
        logic [31:0] d;
        int          c;
    } exp_t;
    exp_t q[$];

    imem_loader_if #(.ADDR_W(6)) bus ();

    imem_loader #(.ADDR_W(6), .DEPTH(64)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Every write pulse must match the oldest queued word, in the expected cycle.
    always @(negedge clk) begin
        if (rstn === 1'b1) begin
            if (bus.we === 1'b1) begin
                total++;
                assert (q.size() != 0) else begin
                    bad++;
                    $error("FAIL we_unexpected observed waddr=%h wdata=%h expected no write", bus.waddr, bus.wdata);
                end
                if (q.size() != 0) begin
                    exp_t e;
                    e = q.pop_front();
                    chk("waddr", 32'(bus.waddr), 32'(e.a));
                    chk("wdata", bus.wdata, e.d);
                    chk("we_cycle", 32'(cyc), 32'(e.c));
                end
            end else if (q.size() != 0 && q[0].c <= cyc) begin
                chk("we_missing", 32'(bus.we), 32'd1);
                void'(q.pop_front());
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        @(negedge clk);
        bus.byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit is_data, input int addr, input int gapmax);
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            if (gapmax > 0) idle($urandom_range(0, gapmax));
            if (is_data && i == 3) begin
                e.a = addr[5:0];
                e.d = w;
                e.c = cyc + 1;
                q.push_back(e);
            end
            send_byte(w[8*i +: 8]);
        end
    endtask

    task automatic pulse_restart();
        bus.restart = 1'b1;
        @(negedge clk);
        bus.restart = 1'b0;
    endtask

    logic [31:0] w;

    initial begin
        total = 0;
        bad   = 0;
        rstn  = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        bus.restart    = 1'b0;
        idle(3);
        chk("rst_we", 32'(bus.we), 32'd0);
        chk("rst_waddr", 32'(bus.waddr), 32'd0);
        chk("rst_wdata", bus.wdata, 32'd0);
        chk("rst_done", 32'(bus.load_done), 32'd0);
        chk("rst_err", 32'(bus.load_err), 32'd0);
        rstn = 1'b1;
        idle(1);
        chk("rst_ready", 32'(bus.byte_ready), 32'd1);

        // Nominal two-word load, back-to-back
        send_word(32'd2, 1'b0, 0, 0);
        send_word(32'h0000_00EF, 1'b1, 0, 0);
        send_word(32'hFE01_0113, 1'b1, 1, 0);
        chk("nom_we_last", 32'(bus.we), 32'd1);
        chk("nom_done_early", 32'(bus.load_done), 32'd0);
        idle(1);
        chk("nom_done", 32'(bus.load_done), 32'd1);
        chk("nom_ready", 32'(bus.byte_ready), 32'd0);
        chk("nom_q_empty", 32'(q.size()), 32'd0);

        // Traffic while DONE is ignored
        for (int i = 0; i < 10; i++) begin
            bus.byte_valid = 1'b1;
            bus.byte_data  = 8'($urandom);
            @(negedge clk);
            chk("ign_done", 32'(bus.load_done), 32'd1);
            chk("ign_ready", 32'(bus.byte_ready), 32'd0);
            chk("ign_waddr", 32'(bus.waddr), 32'd2);
        end
        bus.byte_valid = 1'b0;
        pulse_restart();
        chk("rs1_done", 32'(bus.load_done), 32'd0);
        chk("rs1_ready", 32'(bus.byte_ready), 32'd1);

        // Zero length
        send_word(32'd0, 1'b0, 0, 0);
        chk("zero_done", 32'(bus.load_done), 32'd1);
        chk("zero_ready", 32'(bus.byte_ready), 32'd0);
        idle(2);
        chk("zero_ready2", 32'(bus.byte_ready), 32'd0);
        pulse_restart();
        chk("rs2_done", 32'(bus.load_done), 32'd0);

        // Overflow N=65
        send_word(32'd65, 1'b0, 0, 0);
        chk("ovf_err", 32'(bus.load_err), 32'd1);
        chk("ovf_ready", 32'(bus.byte_ready), 32'd0);
        chk("ovf_done", 32'(bus.load_done), 32'd0);
        for (int i = 0; i < 8; i++) send_byte(8'($urandom));
        chk("ovf_err_hold", 32'(bus.load_err), 32'd1);
        pulse_restart();
        chk("rs3_err", 32'(bus.load_err), 32'd0);
        chk("rs3_ready", 32'(bus.byte_ready), 32'd1);

        // Full depth with random gaps
        send_word(32'd64, 1'b0, 0, 2);
        for (int i = 0; i < 64; i++) begin
            w = $urandom;
            send_word(w, 1'b1, i, 3);
        end
        chk("full_done_early", 32'(bus.load_done), 32'd0);
        idle(1);
        chk("full_done", 32'(bus.load_done), 32'd1);
        idle(3);
        chk("full_q_empty", 32'(q.size()), 32'd0);
        pulse_restart();

        // Reset in the middle of word 1
        send_word(32'd2, 1'b0, 0, 0);
        send_word(32'h1122_3344, 1'b1, 0, 1);
        send_byte(8'hAA);
        send_byte(8'hBB);
        rstn = 1'b0;
        #1;
        chk("mid_rst_done", 32'(bus.load_done), 32'd0);
        chk("mid_rst_we", 32'(bus.we), 32'd0);
        chk("mid_rst_waddr", 32'(bus.waddr), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        idle(1);
        chk("mid_ready", 32'(bus.byte_ready), 32'd1);
        send_word(32'd1, 1'b0, 0, 0);
        send_word(32'hCAFE_F00D, 1'b1, 0, 0);
        idle(1);
        chk("mid_done", 32'(bus.load_done), 32'd1);
        idle(3);
        chk("mid_q_empty", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
